// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart_tx_sched packet scheduler.
// Optional checksum byte: define TX_SCHED_CHECKSUM_EN.
package uart_pkg;

   localparam int ID_W = 4;
   localparam logic [3:0] HDR_MAGIC_DEF = 4'hA;

`ifdef TX_SCHED_CHECKSUM_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_ISSUE,
      S_ACK,
      S_DRAIN,
      S_FETCH,
      S_CSUM,
      S_END
   } state_e;
`else
   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_ISSUE,
      S_ACK,
      S_DRAIN,
      S_FETCH,
      S_END
   } state_e;
`endif

   function automatic logic [7:0] hdr_byte(
      input logic [3:0]      magic,
      input logic [ID_W-1:0] id
   );
      return {magic, id};
   endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin search starting one past the pointer.
// The pointer register lives in the parent.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] id,
   output logic            any
);

   int best_d;
   int best_i;
   int d;

   always_comb begin
      best_d = N;
      best_i = 0;
      d      = 0;
      // distance from ptr+1, wrapping modulo N
      for (int i = 0; i < N; i++) begin
         d = (i + N - 1 - int'(ptr)) % N;
         if (req[i] && d < best_d) begin
            best_d = d;
            best_i = i;
         end
      end
      any = (best_d < N);
      for (int i = 0; i < N; i++) begin
         gnt[i] = any && (i == best_i);
      end
      id = ID_W'(best_i);
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin packet scheduler feeding one async transmitter.
// Optional checksum byte per packet: define TX_SCHED_CHECKSUM_EN.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int         N         = 4,
   parameter int         TIMEOUT   = 4096,
   parameter logic [3:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req_valid,
   input  logic [8*N-1:0]   req_data,
   input  logic [N-1:0]     req_last,
   output logic [N-1:0]     req_ready,
   output logic             tx_start,
   output logic [7:0]       tx_data,
   input  logic             tx_busy,
   output logic [ID_W-1:0]  grant_id,
   output logic             pkt_active,
   output logic             err_timeout
);

   localparam int CW = $clog2(TIMEOUT + 1);

   state_e          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] grant_q, grant_d;
   logic [N-1:0]    goh_q, goh_d;
   logic [7:0]      byte_q, byte_d;
   logic            last_q, last_d;
   logic [CW-1:0]   stall_q, stall_d;
   logic            tx_start_q, tx_start_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            active_q, active_d;
   logic            err_q, err_d;
`ifdef TX_SCHED_CHECKSUM_EN
   logic [7:0]      csum_q, csum_d;
   logic            cdone_q, cdone_d;
`endif

   logic [N-1:0]    arb_gnt;
   logic [ID_W-1:0] arb_id;
   logic            arb_any;

   logic            sel_valid;
   logic            sel_last;
   logic [7:0]      sel_data;

   rr_arbiter #(.N(N)) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .id  (arb_id),
      .any (arb_any)
   );

   always_comb begin
      sel_valid = |(goh_q & req_valid);
      sel_last  = |(goh_q & req_last);
      sel_data  = '0;
      for (int i = 0; i < N; i++) begin
         if (goh_q[i]) sel_data = req_data[i*8 +: 8];
      end
   end

   // accept strobe only ever reaches the granted channel
   assign req_ready = (state_q == S_FETCH) ? (goh_q & req_valid) : '0;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      grant_d    = grant_q;
      goh_d      = goh_q;
      byte_d     = byte_q;
      last_d     = last_q;
      stall_d    = stall_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      active_d   = active_q;
      err_d      = 1'b0;
`ifdef TX_SCHED_CHECKSUM_EN
      csum_d     = csum_q;
      cdone_d    = cdone_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (arb_any) begin
               grant_d  = arb_id;
               goh_d    = arb_gnt;
               ptr_d    = arb_id;
               active_d = 1'b1;
               state_d  = S_HDR;
            end
         end
         S_HDR: begin
            byte_d  = hdr_byte(HDR_MAGIC, grant_q);
            last_d  = 1'b0;
            stall_d = '0;
`ifdef TX_SCHED_CHECKSUM_EN
            csum_d  = hdr_byte(HDR_MAGIC, grant_q);
            cdone_d = 1'b0;
`endif
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = byte_q;
               state_d    = S_ACK;
            end
         end
         S_ACK: begin
            if (tx_busy) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (!tx_busy) begin
               if (!last_q) begin
                  state_d = S_FETCH;
               end else begin
`ifdef TX_SCHED_CHECKSUM_EN
                  state_d = cdone_q ? S_END : S_CSUM;
`else
                  state_d = S_END;
`endif
               end
            end
         end
         S_FETCH: begin
            if (sel_valid) begin
               byte_d  = sel_data;
               last_d  = sel_last;
               stall_d = '0;
`ifdef TX_SCHED_CHECKSUM_EN
               csum_d  = csum_q ^ sel_data;
`endif
               state_d = S_ISSUE;
            end else if (stall_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_END;
            end else begin
               stall_d = stall_q + CW'(1);
            end
         end
`ifdef TX_SCHED_CHECKSUM_EN
         S_CSUM: begin
            byte_d  = csum_q;
            cdone_d = 1'b1;
            state_d = S_ISSUE;
         end
`endif
         S_END: begin
            active_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= ID_W'(N - 1);
         grant_q    <= '0;
         goh_q      <= '0;
         byte_q     <= '0;
         last_q     <= 1'b0;
         stall_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         active_q   <= 1'b0;
         err_q      <= 1'b0;
`ifdef TX_SCHED_CHECKSUM_EN
         csum_q     <= '0;
         cdone_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         goh_q      <= goh_d;
         byte_q     <= byte_d;
         last_q     <= last_d;
         stall_q    <= stall_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         active_q   <= active_d;
         err_q      <= err_d;
`ifdef TX_SCHED_CHECKSUM_EN
         csum_q     <= csum_d;
         cdone_q    <= cdone_d;
`endif
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_data     = tx_data_q;
   assign grant_id    = grant_q;
   assign pkt_active  = active_q;
   assign err_timeout = err_q;

endmodule
